// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer and internal next-PC.
// Optional perf counters (stall_cnt, flush_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned               PC_WIDTH     = 32,
    parameter int unsigned               DATA_WIDTH   = 32,
    parameter int unsigned               PC_STEP      = 4,
    parameter logic [PC_WIDTH-1:0]       RESET_PC     = '0,
    parameter logic [DATA_WIDTH-1:0]     BUBBLE_INSTR = '0,
    parameter int unsigned               CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic                  flush,
    input  logic                  stall,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [PC_WIDTH-1:0]   out_pc_next,
    output logic [DATA_WIDTH-1:0] out_instr
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
`endif
);

    localparam logic [PC_WIDTH-1:0] STEP_L       = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] RESET_PC_NXT = RESET_PC + STEP_L;

    logic                  main_valid_q, main_valid_d;
    logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d;
    logic [PC_WIDTH-1:0]   main_pc_next_q, main_pc_next_d;
    logic [DATA_WIDTH-1:0] main_instr_q, main_instr_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;

    logic push;
    logic pop;

    // in_ready depends only on registered state, so out_ready never reaches it combinationally
    assign in_ready = ~skid_valid_q;
    assign push     = in_valid & ~skid_valid_q;
    assign pop      = main_valid_q & out_ready & ~stall;

    always_comb begin
        main_valid_d   = main_valid_q;
        main_pc_d      = main_pc_q;
        main_pc_next_d = main_pc_next_q;
        main_instr_d   = main_instr_q;
        skid_valid_d   = skid_valid_q;
        skid_pc_d      = skid_pc_q;
        skid_instr_d   = skid_instr_q;

        if (flush) begin
            main_valid_d   = 1'b0;
            skid_valid_d   = 1'b0;
            main_pc_d      = RESET_PC;
            main_pc_next_d = RESET_PC_NXT;
            main_instr_d   = BUBBLE_INSTR;
        end else if (pop) begin
            if (skid_valid_q) begin
                main_pc_d      = skid_pc_q;
                main_pc_next_d = skid_pc_q + STEP_L;
                main_instr_d   = skid_instr_q;
                skid_valid_d   = 1'b0;
            end else if (push) begin
                main_pc_d      = in_pc;
                main_pc_next_d = in_pc + STEP_L;
                main_instr_d   = in_instr;
            end else begin
                main_valid_d   = 1'b0;
                main_pc_d      = RESET_PC;
                main_pc_next_d = RESET_PC_NXT;
                main_instr_d   = BUBBLE_INSTR;
            end
        end else if (push) begin
            if (!main_valid_q) begin
                main_valid_d   = 1'b1;
                main_pc_d      = in_pc;
                main_pc_next_d = in_pc + STEP_L;
                main_instr_d   = in_instr;
            end else begin
                skid_valid_d   = 1'b1;
                skid_pc_d      = in_pc;
                skid_instr_d   = in_instr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_q   <= 1'b0;
            main_pc_q      <= RESET_PC;
            main_pc_next_q <= RESET_PC_NXT;
            main_instr_q   <= BUBBLE_INSTR;
            skid_valid_q   <= 1'b0;
            skid_pc_q      <= RESET_PC;
            skid_instr_q   <= BUBBLE_INSTR;
        end else begin
            main_valid_q   <= main_valid_d;
            main_pc_q      <= main_pc_d;
            main_pc_next_q <= main_pc_next_d;
            main_instr_q   <= main_instr_d;
            skid_valid_q   <= skid_valid_d;
            skid_pc_q      <= skid_pc_d;
            skid_instr_q   <= skid_instr_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_pc_q;
    assign out_pc_next = main_pc_next_q;
    assign out_instr   = main_instr_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate at all-ones rather than wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && !pop && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue model of the 2-deep stage checked every cycle, plus literal expectations.
module tb_pipe_stage_reg;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;
    logic [31:0] out_instr;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    pipe_stage_reg #(
        .PC_WIDTH(32), .DATA_WIDTH(32), .PC_STEP(4),
        .RESET_PC(32'h0), .BUBBLE_INSTR(32'h0), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush), .stall(stall),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .out_instr(out_instr)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: the stage is a FIFO of at most two {pc, instr} entries
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    int          m_stall = 0;
    int          m_flush = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_pc();
        return (q_pc.size() > 0) ? q_pc[0] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_ins();
        return (q_ins.size() > 0) ? q_ins[0] : 32'h0;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid", {63'd0, out_valid}, {63'd0, q_pc.size() > 0});
            check("m_in_ready", {63'd0, in_ready}, {63'd0, q_pc.size() < 2});
            check("m_out_pc", {32'd0, out_pc}, {32'd0, exp_pc()});
            check("m_out_pc_next", {32'd0, out_pc_next}, {32'd0, exp_pc() + 32'd4});
            check("m_out_instr", {32'd0, out_instr}, {32'd0, exp_ins()});
`ifdef PIPE_STAGE_PERF_EN
            check("m_stall_cnt", {60'd0, stall_cnt}, 64'(m_stall));
            check("m_flush_cnt", {60'd0, flush_cnt}, 64'(m_flush));
`endif
        end
    end

    // One clock: drive inputs, advance the model across the edge, end on the next negedge
    task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                        input bit fl, input bit st, input bit ordy);
        bit do_push, do_pop;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        flush     = fl;
        stall     = st;
        out_ready = ordy;
        do_push = iv && (q_pc.size() < 2);
        do_pop  = (q_pc.size() > 0) && ordy && !st;
        @(posedge clk);
        if (q_pc.size() > 0 && !do_pop && m_stall < (1 << CW) - 1) m_stall++;
        if (fl && q_pc.size() > 0 && m_flush < (1 << CW) - 1) m_flush++;
        if (fl) begin
            q_pc.delete();
            q_ins.delete();
        end else begin
            if (do_pop) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (do_push) begin
                q_pc.push_back(pc);
                q_ins.push_back(ins);
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_ins.delete();
        m_stall = 0;
        m_flush = 0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 0; in_pc = 0; in_instr = 0;
        flush = 0; stall = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_pc", {32'd0, out_pc}, 64'h0);
        check("rst_out_pc_next", {32'd0, out_pc_next}, 64'h4);
        check("rst_out_instr", {32'd0, out_instr}, 64'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Single push into EMPTY
        step(1, 32'h100, 32'h2408000A, 0, 0, 1);
        check("t1_valid", {63'd0, out_valid}, 64'd1);
        check("t1_pc", {32'd0, out_pc}, 64'h100);
        check("t1_pc_next", {32'd0, out_pc_next}, 64'h104);
        check("t1_instr", {32'd0, out_instr}, 64'h2408000A);
        check("t1_in_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back stream
        step(1, 32'h104, 32'hA1, 0, 0, 1);
        check("t2_pc_a", {32'd0, out_pc}, 64'h104);
        step(1, 32'h108, 32'hA2, 0, 0, 1);
        check("t2_pc_b", {32'd0, out_pc}, 64'h108);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        check("t2_empty", {63'd0, out_valid}, 64'd0);

        // Fill to FULL, rejected extra push, then drain in order
        step(1, 32'h100, 32'hB0, 0, 0, 0);
        step(1, 32'h200, 32'hB1, 0, 0, 0);
        check("t3_full_in_ready", {63'd0, in_ready}, 64'd0);
        step(1, 32'h300, 32'hB2, 0, 0, 0);
        check("t3_hold_pc", {32'd0, out_pc}, 64'h100);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        check("t3_second_pc", {32'd0, out_pc}, 64'h200);
        check("t3_second_pc_next", {32'd0, out_pc_next}, 64'h204);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        check("t3_drained", {63'd0, out_valid}, 64'd0);
        check("t3_in_ready_back", {63'd0, in_ready}, 64'd1);

        // Stall blocks pop but not push; then flush from FULL with a push pending
        step(1, 32'h500, 32'hC0, 0, 1, 1);
        step(1, 32'h504, 32'hC1, 0, 1, 1);
        check("t4_stall_full", {63'd0, in_ready}, 64'd0);
        step(1, 32'h600, 32'hC2, 1, 0, 1);
        check("t4_flush_valid", {63'd0, out_valid}, 64'd0);
        check("t4_flush_pc", {32'd0, out_pc}, 64'h0);
        check("t4_flush_instr", {32'd0, out_instr}, 64'h0);
        check("t4_flush_in_ready", {63'd0, in_ready}, 64'd1);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        check("t4_nothing_leaks", {63'd0, out_valid}, 64'd0);

        // PC wrap, then asynchronous reset between edges while FULL
        step(1, 32'hFFFFFFFC, 32'hD0, 0, 0, 0);
        check("t5_wrap", {32'd0, out_pc_next}, 64'h0);
        step(1, 32'h10, 32'hD1, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_valid", {63'd0, out_valid}, 64'd0);
        check("t5_async_in_ready", {63'd0, in_ready}, 64'd1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
        step(1, 32'h700, 32'hE0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 32'h0, 32'h0, 0, 1, 1);
        check("t6_stall_sat", {60'd0, stall_cnt}, 64'd15);
        step(0, 32'h0, 32'h0, 1, 0, 0);
        check("t6_flush_cnt", {60'd0, flush_cnt}, 64'd1);
`endif

        // Mixed traffic checked by the model
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 3) != 0, 32'h1000 + 32'(i) * 4, $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) != 0);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
